// File: rtl/trace_pkg.sv
// Shared types and default widths for the instruction-trace packet encoder.
// Packet formats, the packet record, encoder states and the sequential-address helper.
package trace_pkg;

   localparam int DEF_XLEN       = 32;
   localparam int DEF_CAUSE_W    = 5;
   localparam int DEF_PRIV_W     = 3;
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_FIFO_DEPTH = 8;

   typedef enum logic [2:0] {
      START  = 3'd0,
      BRANCH = 3'd1,
      EXC    = 3'd2,
      PRIV   = 3'd3,
      FULL   = 3'd4,
      STOP   = 3'd5
   } trace_format_e;

   typedef struct packed {
      trace_format_e              format;
      logic                       lost;
      logic                       interrupt;
      logic [DEF_PRIV_W-1:0]      priv;
      logic [DEF_CNT_W-1:0]       count;
      logic [DEF_CAUSE_W-1:0]     cause;
      logic [DEF_XLEN-1:0]        addr;
      logic [DEF_XLEN-1:0]        tval;
   } trace_pkt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      TRACE = 2'd2
   } enc_state_e;

   // Address of the instruction that follows one of the given length; wraps modulo 2^XLEN.
   function automatic logic [DEF_XLEN-1:0] seq_next(input logic [DEF_XLEN-1:0] addr,
                                                    input logic len4);
      return addr + (len4 ? DEF_XLEN'(4) : DEF_XLEN'(2));
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with full/empty flags; head is read from registered storage.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module trace_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);

   T               mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           wr_en, rd_en;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rd_en   = pop_i && !empty_o;
   assign wr_en   = push_i && (!full_o || rd_en);
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !rd_en)      count_d = count_q + 1'b1;
      else if (!wr_en && rd_en) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/trace_packet_encoder.sv
// Compresses the retired-instruction stream into discontinuity packets buffered in a FIFO.
// state | meaning
// IDLE  | tracing disabled, waiting for the registered enable
// SYNC  | enabled, next retired instruction emits START (or EXC if it traps)
// TRACE | synchronised; emit packets only on discontinuities
module trace_packet_encoder
   import trace_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int CAUSE_W    = DEF_CAUSE_W,
   parameter int PRIV_W     = DEF_PRIV_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               trace_en_i,
   input  logic               ivalid_i,
   input  logic               iexception_i,
   input  logic               interrupt_i,
   input  logic [CAUSE_W-1:0] cause_i,
   input  logic [XLEN-1:0]    tval_i,
   input  logic [PRIV_W-1:0]  priv_i,
   input  logic [XLEN-1:0]    iaddr_i,
   input  logic [XLEN-1:0]    instr_i,
   output logic               pkt_valid_o,
   input  logic               pkt_ready_i,
   output trace_pkt_t         pkt_o,
   output logic               overflow_o
);

   logic               en_q, ivalid_q, iexc_q, intr_q;
   logic [CAUSE_W-1:0] cause_q;
   logic [XLEN-1:0]    tval_q, iaddr_q, instr_q;
   logic [PRIV_W-1:0]  priv_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q     <= 1'b0;
         ivalid_q <= 1'b0;
         iexc_q   <= 1'b0;
         intr_q   <= 1'b0;
         cause_q  <= '0;
         tval_q   <= '0;
         priv_q   <= '0;
         iaddr_q  <= '0;
         instr_q  <= '0;
      end else begin
         en_q     <= trace_en_i;
         ivalid_q <= ivalid_i;
         iexc_q   <= iexception_i;
         intr_q   <= interrupt_i;
         cause_q  <= cause_i;
         tval_q   <= tval_i;
         priv_q   <= priv_i;
         iaddr_q  <= iaddr_i;
         instr_q  <= instr_i;
      end
   end

   enc_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]    last_addr_q, last_addr_d;
   logic               last_len4_q, last_len4_d;
   logic [PRIV_W-1:0]  last_priv_q, last_priv_d;
   logic               lost_q, lost_d;
   logic               overflow_q, overflow_d;

   logic               emit, push, can_push, pop, fifo_full, fifo_empty;
   logic [XLEN-1:0]    next_addr;
   trace_pkt_t         pkt_new;

   assign pop       = pkt_valid_o && pkt_ready_i;
   assign can_push  = !fifo_full || pop;
   assign next_addr = seq_next(last_addr_q, last_len4_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_addr_d = last_addr_q;
      last_len4_d = last_len4_q;
      last_priv_d = last_priv_q;
      lost_d      = lost_q;
      overflow_d  = trace_en_i ? overflow_q : 1'b0;
      emit        = 1'b0;
      push        = 1'b0;
      pkt_new     = '0;
      pkt_new.addr  = iaddr_q;
      pkt_new.count = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (en_q) state_d = SYNC;
         end
         SYNC: begin
            if (!en_q) begin
               state_d = IDLE;
            end else if (ivalid_q) begin
               emit = 1'b1;
               if (iexc_q) begin
                  pkt_new.format    = EXC;
                  pkt_new.cause     = cause_q;
                  pkt_new.tval      = tval_q;
                  pkt_new.interrupt = intr_q;
               end else begin
                  pkt_new.format = START;
                  pkt_new.priv   = priv_q;
                  pkt_new.count  = '0;
                  state_d        = TRACE;
               end
            end
         end
         TRACE: begin
            if (!en_q) begin
               emit           = 1'b1;
               pkt_new.format = STOP;
               pkt_new.addr   = last_addr_q;
               state_d        = IDLE;
            end else if (ivalid_q) begin
               emit = 1'b1;
               if (iexc_q) begin
                  pkt_new.format    = EXC;
                  pkt_new.cause     = cause_q;
                  pkt_new.tval      = tval_q;
                  pkt_new.interrupt = intr_q;
                  state_d           = SYNC;
               end else if (priv_q != last_priv_q) begin
                  pkt_new.format = PRIV;
                  pkt_new.priv   = priv_q;
               end else if (iaddr_q != next_addr) begin
                  pkt_new.format = BRANCH;
               end else if (cnt_q == {CNT_W{1'b1}}) begin
                  pkt_new.format = FULL;
               end else begin
                  emit  = 1'b0;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (en_q && ivalid_q && (state_q != IDLE)) begin
         last_addr_d = iaddr_q;
         last_len4_d = (instr_q[1:0] == 2'b11);
         last_priv_d = priv_q;
      end

      // A dropped packet forces a resync so the sink can recover absolute state.
      if (emit) begin
         cnt_d = '0;
         if (can_push) begin
            push         = 1'b1;
            pkt_new.lost = lost_q;
            lost_d       = 1'b0;
         end else begin
            overflow_d = 1'b1;
            lost_d     = 1'b1;
            state_d    = SYNC;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_addr_q <= '0;
         last_len4_q <= 1'b0;
         last_priv_q <= '0;
         lost_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_addr_q <= last_addr_d;
         last_len4_q <= last_len4_d;
         last_priv_q <= last_priv_d;
         lost_q      <= lost_d;
         overflow_q  <= overflow_d;
      end
   end

   assign overflow_o  = overflow_q;
   assign pkt_valid_o = !fifo_empty;

   trace_fifo #(
      .T     (trace_pkt_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (pkt_new),
      .pop_i   (pop),
      .data_o  (pkt_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule
